// File: rtl/awgn_pkg.sv
// Shared constants for the AWGN channel adder: sample widths, Q-format
// fraction bits, rounding constant and saturation limits.
package awgn_pkg;
  localparam int DW     = 16;            // symbol / noise / output, Q4.11
  localparam int SW     = 16;            // sigma, unsigned Q1.15
  localparam int FRAC_D = 11;
  localparam int FRAC_S = 15;
  localparam int PW     = 32;            // noise * sigma product, Q5.26
  // Product carries FRAC_D+FRAC_S fraction bits; drop back to FRAC_D.
  localparam int SHIFT  = (FRAC_D + FRAC_S) - FRAC_D;

  localparam logic signed [PW-1:0] ROUND_CONST = PW'(1) <<< (SHIFT - 1);
  localparam logic signed [DW-1:0] SAT_MAX     = 16'sh7FFF;
  localparam logic signed [DW-1:0] SAT_MIN     = 16'sh8000;
endpackage

// File: rtl/awgn_scale_sat.sv
// Combinational per-component stage: round the scaled noise back to Q5.11,
// add it to the symbol and saturate to the DW-bit signed range.
module awgn_scale_sat
  import awgn_pkg::*;
(
  input  logic signed [PW-1:0] i_prod,
  input  logic                 i_en,
  input  logic signed [DW-1:0] i_sym,
  output logic signed [DW-1:0] o_out,
  output logic                 o_clip
);
  logic signed [PW-1:0] w_rnd;
  logic signed [DW:0]   w_n;
  logic signed [DW+1:0] w_sym_x;
  logic signed [DW+1:0] w_n_x;
  logic signed [DW+1:0] w_sum;
  logic                 w_unused;

  // The product magnitude stays below 2^31 - 2^14, so the round add cannot wrap.
  assign w_rnd    = i_prod + ROUND_CONST;
  assign w_n      = w_rnd[PW-1:SHIFT];
  assign w_unused = ^w_rnd[SHIFT-1:0];
  assign w_sym_x  = (DW+2)'(i_sym);
  assign w_n_x    = i_en ? (DW+2)'(w_n) : '0;
  assign w_sum    = w_sym_x + w_n_x;

  always_comb begin
    o_out  = w_sum[DW-1:0];
    o_clip = 1'b0;
    if (w_sum > (DW+2)'(SAT_MAX)) begin
      o_out  = SAT_MAX;
      o_clip = 1'b1;
    end else if (w_sum < (DW+2)'(SAT_MIN)) begin
      o_out  = SAT_MIN;
      o_clip = 1'b1;
    end
  end
endmodule

// File: rtl/awgn_channel_adder.sv
// Adds sigma-scaled Gaussian noise to a complex symbol stream, 2-stage
// valid/ready pipeline. Define AWGN_SAT_CNT_EN to add a saturation counter.
module awgn_channel_adder
  import awgn_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] noise_i,
  input  logic signed [DW-1:0] noise_q,
  input  logic        [SW-1:0] sigma,
  input  logic                 noise_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_i,
  input  logic signed [DW-1:0] in_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_i,
  output logic signed [DW-1:0] out_q
`ifdef AWGN_SAT_CNT_EN
  ,
  input  logic                 sat_clr,
  output logic [15:0]          sat_cnt
`endif
);
  logic                 r_s1_valid, r_s1_en, r_out_valid;
  logic signed [DW-1:0] r_s1_i, r_s1_q, r_out_i, r_out_q;
  logic signed [PW-1:0] r_p_i, r_p_q;
  logic signed [PW-1:0] w_p_i, w_p_q, w_sigma_x;
  logic signed [DW-1:0] w_sat_i, w_sat_q;
  logic                 w_clip_i, w_clip_q;
  logic                 w_advance, w_accept, w_s2_load;

  assign w_advance = !r_out_valid | out_ready;
  assign in_ready  = !r_s1_valid | w_advance;
  assign w_accept  = in_valid & in_ready;
  assign w_s2_load = r_s1_valid & w_advance;

  // Sigma is unsigned: zero-extend before the signed multiply.
  assign w_sigma_x = PW'($signed({1'b0, sigma}));
  assign w_p_i     = PW'(noise_i) * w_sigma_x;
  assign w_p_q     = PW'(noise_q) * w_sigma_x;

  awgn_scale_sat u_sat_i (
    .i_prod(r_p_i), .i_en(r_s1_en), .i_sym(r_s1_i), .o_out(w_sat_i), .o_clip(w_clip_i)
  );
  awgn_scale_sat u_sat_q (
    .i_prod(r_p_q), .i_en(r_s1_en), .i_sym(r_s1_q), .o_out(w_sat_q), .o_clip(w_clip_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_en     <= 1'b0;
      r_s1_i      <= '0;
      r_s1_q      <= '0;
      r_p_i       <= '0;
      r_p_q       <= '0;
      r_out_valid <= 1'b0;
      r_out_i     <= '0;
      r_out_q     <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_en    <= noise_en;
        r_s1_i     <= in_i;
        r_s1_q     <= in_q;
        r_p_i      <= w_p_i;
        r_p_q      <= w_p_q;
      end else if (w_advance) begin
        r_s1_valid <= 1'b0;
      end
      if (w_advance) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_i <= w_sat_i;
          r_out_q <= w_sat_q;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_i     = r_out_i;
  assign out_q     = r_out_q;

`ifdef AWGN_SAT_CNT_EN
  logic [15:0] r_sat_cnt;
  logic [16:0] w_cnt_sum;

  assign w_cnt_sum = {1'b0, r_sat_cnt} + 17'(w_clip_i) + 17'(w_clip_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_sat_cnt <= '0;
    else if (sat_clr)   r_sat_cnt <= '0;
    else if (w_s2_load) r_sat_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
  end

  assign sat_cnt = r_sat_cnt;
`endif
endmodule
